prim_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the Prim 16-bit memory bus (addr/dat/bs/we/ack).
- Shares one memory port between the Prim CPU (master 0) and a second master (master 1, e.g. loader/DMA/debug).
- Round-robin grant, held until the slave acks. A per-transaction watchdog terminates transactions the slave never acks and flags a bus error.

---
 rtl/prim_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_prim_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/prim_bus_arbiter.sv
// Two-master, one-slave arbiter for the Prim 16-bit memory bus.
// Round-robin grant held until slave ack, with a per-transaction watchdog.
module prim_bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_m0_addr,
    input  logic [15:0] i_m0_dat,
    output logic [15:0] o_m0_dat,
    input  logic [1:0]  i_m0_bs,
    input  logic        i_m0_we,
    output logic        o_m0_ack,
    input  logic [15:0] i_m1_addr,
    input  logic [15:0] i_m1_dat,
    output logic [15:0] o_m1_dat,
    input  logic [1:0]  i_m1_bs,
    input  logic        i_m1_we,
    output logic        o_m1_ack,
    output logic [15:0] o_s_addr,
    output logic [15:0] o_s_dat,
    input  logic [15:0] i_s_dat,
    output logic [1:0]  o_s_bs,
    output logic        o_s_we,
    input  logic        i_s_ack,
    output logic [1:0]  o_grant,
    output logic        o_err,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a master requests by holding bs != 0 with stable addr/dat/we
    // until it sees its ack; ack completes the access in that same cycle.
    // Dropping bs before ack abandons the access without an ack.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [TW-1:0] WDOG_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state, state_nx;
    logic          r_last, last_nx;
    logic [TW-1:0] r_wdog, wdog_nx;

    logic req0, req1, req_cur, granted, gnt_sel, timeout, done;

    assign req0    = |i_m0_bs;
    assign req1    = |i_m1_bs;
    assign granted = (state == GNT0) || (state == GNT1);
    assign gnt_sel = (state == GNT1);
    assign req_cur = gnt_sel ? req1 : req0;
    // A real ack in the expiry cycle wins, so timeout is qualified by !i_s_ack.
    assign timeout = (TIMEOUT != 0) && granted && !i_s_ack && (r_wdog == WDOG_LAST);
    assign done    = granted && (i_s_ack || timeout);

    assign o_dbg_state = state;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            r_last <= 1'b1;
            r_wdog <= '0;
        end else begin
            state  <= state_nx;
            r_last <= last_nx;
            r_wdog <= wdog_nx;
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = r_last;
        wdog_nx  = r_wdog;
        case (state)
            IDLE: begin
                wdog_nx = '0;
                if (req0 && (!req1 || r_last)) state_nx = GNT0;
                else if (req1)                 state_nx = GNT1;
            end
            GNT0, GNT1: begin
                if (done) begin
                    state_nx = IDLE;
                    last_nx  = gnt_sel;
                end else if (!req_cur) begin
                    state_nx = IDLE;
                end else begin
                    wdog_nx = r_wdog + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_s_addr = '0;
        o_s_dat  = '0;
        o_s_bs   = '0;
        o_s_we   = 1'b0;
        o_grant  = 2'b00;
        o_m0_ack = 1'b0;
        o_m1_ack = 1'b0;
        o_err    = 1'b0;
        o_m0_dat = i_s_dat;
        o_m1_dat = i_s_dat;
        if (i_reset_n) begin
            case (state)
                GNT0: begin
                    o_s_addr = i_m0_addr;
                    o_s_dat  = i_m0_dat;
                    o_s_bs   = i_m0_bs;
                    o_s_we   = i_m0_we;
                    o_grant  = 2'b01;
                    o_m0_ack = i_s_ack || timeout;
                    if (timeout) o_m0_dat = 16'hFFFF;
                end
                GNT1: begin
                    o_s_addr = i_m1_addr;
                    o_s_dat  = i_m1_dat;
                    o_s_bs   = i_m1_bs;
                    o_s_we   = i_m1_we;
                    o_grant  = 2'b10;
                    o_m1_ack = i_s_ack || timeout;
                    if (timeout) o_m1_dat = 16'hFFFF;
                end
                default: ;
            endcase
            o_err = timeout;
        end
    end

endmodule

// File: tb/tb_prim_bus_arbiter.sv
// Self-checking bench for prim_bus_arbiter: directed phases plus an ack
// scoreboard keyed on {err, master, read data}.
module tb_prim_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [15:0] i_m0_addr, i_m0_dat, i_m1_addr, i_m1_dat, i_s_dat;
    logic [1:0]  i_m0_bs, i_m1_bs;
    logic        i_m0_we, i_m1_we, i_s_ack;
    logic [15:0] o_m0_dat, o_m1_dat, o_s_addr, o_s_dat;
    logic        o_m0_ack, o_m1_ack, o_s_we, o_err;
    logic [1:0]  o_s_bs, o_grant, o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard entry: {err, master index, data seen by that master}
    logic [17:0] exp_q[$];
    logic [17:0] mon_obs, mon_exp;

    logic [1:0] rr_seq [7];

    prim_bus_arbiter #(.TIMEOUT(4), .TW(8)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat), .o_m0_dat(o_m0_dat),
        .i_m0_bs(i_m0_bs), .i_m0_we(i_m0_we), .o_m0_ack(o_m0_ack),
        .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat), .o_m1_dat(o_m1_dat),
        .i_m1_bs(i_m1_bs), .i_m1_we(i_m1_we), .o_m1_ack(o_m1_ack),
        .o_s_addr(o_s_addr), .o_s_dat(o_s_dat), .i_s_dat(i_s_dat),
        .o_s_bs(o_s_bs), .o_s_we(o_s_we), .i_s_ack(i_s_ack),
        .o_grant(o_grant), .o_err(o_err), .o_dbg_state(o_dbg_state)
    );

    // Clock / time bound
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL time_limit: bench still running at %0t, required finish earlier", $time);
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bus_quiet();
        i_m0_bs = 2'b00; i_m1_bs = 2'b00;
        i_m0_we = 1'b0;  i_m1_we = 1'b0;
        i_s_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"}, 32'(o_grant), 0);
        check_eq({tag, "_sbs"},   32'(o_s_bs), 0);
        check_eq({tag, "_swe"},   32'(o_s_we), 0);
        check_eq({tag, "_acks"},  32'({o_m1_ack, o_m0_ack}), 0);
        check_eq({tag, "_err"},   32'(o_err), 0);
    endtask

    // Ack monitor: every master ack must match the oldest expected completion.
    always @(negedge i_clk) begin
        #2;
        if (o_m0_ack || o_m1_ack) begin
            check_eq("ack_onehot", 32'(o_m0_ack & o_m1_ack), 0);
            mon_obs = {o_err, o_m1_ack, o_m1_ack ? o_m1_dat : o_m0_dat};
            if (exp_q.size() == 0) begin
                check_eq("ack_unexpected", 32'({o_m1_ack, o_m0_ack}), 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("ack_txn", 32'(mon_obs), 32'(mon_exp));
            end
        end
    end

    initial begin
        rr_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        i_reset_n = 1'b0;
        i_m0_addr = 16'h1111; i_m0_dat = 16'h0000;
        i_m1_addr = 16'h2222; i_m1_dat = 16'h0000;
        i_m0_bs = 2'b01; i_m1_bs = 2'b01;
        i_m0_we = 1'b1;  i_m1_we = 1'b1;
        i_s_ack = 1'b1;  i_s_dat = 16'h0000;

        // Reset held with both requesting and a stray slave ack
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk); #1;
            check_all_zero("rst");
        end
        @(negedge i_clk);
        i_reset_n = 1'b1; i_s_ack = 1'b0; i_m0_we = 1'b0; i_m1_we = 1'b0;
        #1 check_eq("rel_idle_grant", 32'(o_grant), 32'h0);
        @(negedge i_clk); #1;
        check_eq("rel_grant0", 32'(o_grant), 32'h1);
        check_eq("rel_saddr", 32'(o_s_addr), 32'h1111);
        @(negedge i_clk);
        i_s_ack = 1'b1; i_s_dat = 16'hAAAA;
        exp_q.push_back({1'b0, 1'b0, 16'hAAAA});
        @(negedge i_clk);
        bus_quiet();

        // Single master read, ack two cycles after grant
        @(negedge i_clk);
        i_m1_bs = 2'b11; i_m1_addr = 16'h1234;
        @(negedge i_clk); #1;
        check_eq("rd_grant", 32'(o_grant), 32'h2);
        check_eq("rd_saddr", 32'(o_s_addr), 32'h1234);
        check_eq("rd_sbs", 32'(o_s_bs), 32'h3);
        @(negedge i_clk); #1;
        check_eq("rd_noack", 32'({o_m1_ack, o_m0_ack}), 32'h0);
        @(negedge i_clk);
        i_s_ack = 1'b1; i_s_dat = 16'hBEEF;
        exp_q.push_back({1'b0, 1'b1, 16'hBEEF});
        #1;
        check_eq("rd_m1ack", 32'(o_m1_ack), 32'h1);
        check_eq("rd_m1dat", 32'(o_m1_dat), 32'hBEEF);
        check_eq("rd_m0ack", 32'(o_m0_ack), 32'h0);
        @(negedge i_clk);
        bus_quiet();
        #1 check_eq("rd_after_grant", 32'(o_grant), 32'h0);

        // Contention: both request, slave acks every cycle
        @(negedge i_clk);
        i_m0_bs = 2'b01; i_m1_bs = 2'b10; i_s_ack = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge i_clk);
            i_s_dat = 16'h5000 + 16'(i);
            if (rr_seq[i] != 2'b00) exp_q.push_back({1'b0, rr_seq[i][1], 16'h5000 + 16'(i)});
            #1 check_eq($sformatf("rr_grant%0d", i), 32'(o_grant), 32'(rr_seq[i]));
        end
        @(negedge i_clk);
        bus_quiet();

        // Write routing: only the granted master's fields reach the slave
        @(negedge i_clk);
        i_m0_bs = 2'b01; i_m0_we = 1'b1; i_m0_addr = 16'h0040; i_m0_dat = 16'h00A5;
        i_m1_bs = 2'b11; i_m1_we = 1'b1; i_m1_addr = 16'hBBBB; i_m1_dat = 16'hCCCC;
        @(negedge i_clk);
        i_s_ack = 1'b1; i_s_dat = 16'h0000;
        exp_q.push_back({1'b0, 1'b0, 16'h0000});
        #1;
        check_eq("wr0_saddr", 32'(o_s_addr), 32'h0040);
        check_eq("wr0_sdat", 32'(o_s_dat), 32'h00A5);
        check_eq("wr0_sbs", 32'(o_s_bs), 32'h1);
        check_eq("wr0_swe", 32'(o_s_we), 32'h1);
        @(negedge i_clk);
        i_m0_bs = 2'b00; i_s_ack = 1'b0;
        #1;
        check_eq("wr_idle_saddr", 32'(o_s_addr), 32'h0);
        check_eq("wr_idle_sbs", 32'(o_s_bs), 32'h0);
        @(negedge i_clk);
        i_s_ack = 1'b1; i_s_dat = 16'h0011;
        exp_q.push_back({1'b0, 1'b1, 16'h0011});
        #1;
        check_eq("wr1_grant", 32'(o_grant), 32'h2);
        check_eq("wr1_saddr", 32'(o_s_addr), 32'hBBBB);
        check_eq("wr1_sdat", 32'(o_s_dat), 32'hCCCC);
        @(negedge i_clk);
        bus_quiet();

        // Watchdog expiry on the 4th granted cycle, then a real ack on the 4th
        @(negedge i_clk);
        i_m0_bs = 2'b01; i_s_dat = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk); #1;
            check_eq($sformatf("wd_wait%0d", i), 32'({o_err, o_m0_ack}), 32'h0);
        end
        @(negedge i_clk);
        exp_q.push_back({1'b1, 1'b0, 16'hFFFF});
        #1;
        check_eq("wd_ack", 32'(o_m0_ack), 32'h1);
        check_eq("wd_err", 32'(o_err), 32'h1);
        check_eq("wd_m0dat", 32'(o_m0_dat), 32'hFFFF);
        check_eq("wd_m1dat", 32'(o_m1_dat), 32'h1234);
        @(negedge i_clk); #1;
        check_eq("wd_idle", 32'(o_grant), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk); #1;
            check_eq($sformatf("wd2_wait%0d", i), 32'({o_err, o_m0_ack}), 32'h0);
        end
        @(negedge i_clk);
        i_s_ack = 1'b1; i_s_dat = 16'h4321;
        exp_q.push_back({1'b0, 1'b0, 16'h4321});
        #1;
        check_eq("wd2_ack", 32'(o_m0_ack), 32'h1);
        check_eq("wd2_err", 32'(o_err), 32'h0);
        @(negedge i_clk);
        bus_quiet();

        // Abort by dropping request, then reset mid-transaction
        @(negedge i_clk);
        i_m1_bs = 2'b01;
        @(negedge i_clk); #1;
        check_eq("ab_grant", 32'(o_grant), 32'h2);
        @(negedge i_clk);
        i_m1_bs = 2'b00;
        #1 check_eq("ab_noack", 32'({o_m1_ack, o_m0_ack}), 32'h0);
        @(negedge i_clk);
        i_m0_bs = 2'b01;
        #1 check_eq("ab_idle", 32'(o_grant), 32'h0);
        @(negedge i_clk); #1;
        check_eq("rs_grant", 32'(o_grant), 32'h1);
        @(negedge i_clk);
        i_reset_n = 1'b0; i_s_ack = 1'b1; i_s_dat = 16'h7777;
        #1 check_all_zero("rs_mid");
        @(negedge i_clk);
        i_reset_n = 1'b1; i_s_ack = 1'b0;
        #1 check_eq("rs_idle", 32'(o_grant), 32'h0);
        @(negedge i_clk);
        i_s_ack = 1'b1; i_s_dat = 16'h9999;
        exp_q.push_back({1'b0, 1'b0, 16'h9999});
        #1 check_eq("rs_regrant", 32'(o_grant), 32'h1);
        @(negedge i_clk);
        bus_quiet();

        repeat (3) @(negedge i_clk);
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
